imem_boot_loader: RTL and testbench

- Boot-time controller for the instruction memory of the five-stage pipeline.
- Accepts a valid/ready stream of instruction words and writes them to sequential instruction-memory addresses.
- Holds the pipeline in stall until loading completes, then hands the memory address port to the fetch stage.
- Sits between the external boot/host interface, the instruction memory, and the IF stage.

---
 rtl/imem_boot_loader.sv | 117 +++++++++++
 tb/tb_imem_boot_loader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Boot loader: streams instruction words into sequential imem addresses, then hands the port to IF.
// Optional running checksum of the current load is enabled with `define IMEM_LOAD_CHECKSUM_EN.
module imem_boot_loader #(
    parameter int                 DATA_W    = 16,
    parameter int                 ADDR_W    = 20,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
`ifdef IMEM_LOAD_CHECKSUM_EN
    output logic [DATA_W-1:0] load_csum,
`endif
    output logic [ADDR_W:0]   word_count
);

    // Valid/ready: a word transfers on any rising edge where in_valid && in_ready;
    // in_ready depends only on the state, never on in_valid.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] write_addr;
    logic              handshake;
    logic              at_top;
    logic              restart;

    assign in_ready  = (state == LOAD);
    assign handshake = in_valid && in_ready;
    assign at_top    = (wr_addr == {ADDR_W{1'b1}});
    assign restart   = start && (state != LOAD);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = LOAD;
            LOAD: begin
                if (handshake) begin
                    if (in_last)     state_next = DONE;
                    else if (at_top) state_next = ERR;
                end
            end
            DONE: if (start) state_next = LOAD;
            ERR:  if (start) state_next = LOAD;
            default: state_next = IDLE;
        endcase
    end

    // A registered write in flight keeps the port even on the first DONE cycle.
    always_comb begin
        mem_addr = wr_addr;
        if (mem_we)             mem_addr = write_addr;
        else if (state == DONE) mem_addr = fetch_addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr_addr    <= BASE_ADDR;
            write_addr <= BASE_ADDR;
            word_count <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            state     <= state_next;
            mem_we    <= handshake;
            cpu_hold  <= (state_next != DONE);
            load_done <= (state_next == DONE);
            load_err  <= (state_next == ERR);
            if (handshake) begin
                write_addr <= wr_addr;
                mem_wdata  <= in_data;
                wr_addr    <= wr_addr + ADDR_ONE;
                word_count <= word_count + COUNT_ONE;
            end else if (restart) begin
                wr_addr    <= BASE_ADDR;
                word_count <= '0;
            end
        end
    end

`ifdef IMEM_LOAD_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_csum <= '0;
        end else if (handshake) begin
            load_csum <= load_csum + in_data;
        end else if (restart) begin
            load_csum <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: three configurations share one random stream, each checked
// against its own behavioural model of the load protocol.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_last = 1'b0;
    logic [19:0] fetch_addr = '0;

    logic        we_o[3];
    logic        rdy_o[3];
    logic        hold_o[3];
    logic        done_o[3];
    logic        err_o[3];
    logic [15:0] wd_o[3];
    logic [15:0] cs_o[3];
    logic [19:0] addr_o[2];
    logic [20:0] cnt_o[2];
    logic [2:0]  addr2;
    logic [3:0]  cnt2;

    int errors = 0;
    int checks = 0;

    // model state per instance: 0 idle, 1 loading, 2 done, 3 error
    int phase[3];
    int next_addr[3];
    int count[3];
    int csum[3];
    int ewe[3];
    int ewaddr[3];
    int ewdata[3];
    int base[3] = '{0, 'h100, 0};
    int top[3]  = '{'hFFFFF, 'hFFFFF, 7};
    logic [35:0] exp_q[$];

    always #5 clk = ~clk;

    imem_boot_loader u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(rdy_o[0]), .fetch_addr(fetch_addr), .mem_we(we_o[0]),
        .mem_addr(addr_o[0]), .mem_wdata(wd_o[0]), .cpu_hold(hold_o[0]), .load_done(done_o[0]),
        .load_err(err_o[0]),
`ifdef IMEM_LOAD_CHECKSUM_EN
        .load_csum(cs_o[0]),
`endif
        .word_count(cnt_o[0])
    );

    imem_boot_loader #(.BASE_ADDR(20'h00100)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(rdy_o[1]), .fetch_addr(fetch_addr), .mem_we(we_o[1]),
        .mem_addr(addr_o[1]), .mem_wdata(wd_o[1]), .cpu_hold(hold_o[1]), .load_done(done_o[1]),
        .load_err(err_o[1]),
`ifdef IMEM_LOAD_CHECKSUM_EN
        .load_csum(cs_o[1]),
`endif
        .word_count(cnt_o[1])
    );

    imem_boot_loader #(.ADDR_W(3), .BASE_ADDR(3'd0)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(rdy_o[2]), .fetch_addr(fetch_addr[2:0]), .mem_we(we_o[2]),
        .mem_addr(addr2), .mem_wdata(wd_o[2]), .cpu_hold(hold_o[2]), .load_done(done_o[2]),
        .load_err(err_o[2]),
`ifdef IMEM_LOAD_CHECKSUM_EN
        .load_csum(cs_o[2]),
`endif
        .word_count(cnt2)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            phase[i] = 0; next_addr[i] = base[i]; count[i] = 0; csum[i] = 0;
            ewe[i] = 0; ewaddr[i] = base[i]; ewdata[i] = 0;
        end
        exp_q.delete();
    endtask

    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            ewe[i] = 0;
            if (phase[i] == 1 && in_valid) begin
                ewe[i] = 1;
                ewaddr[i] = next_addr[i];
                ewdata[i] = int'(in_data);
                if (i == 0) exp_q.push_back({next_addr[i][19:0], in_data});
                count[i]++;
                csum[i] = (csum[i] + int'(in_data)) & 'hFFFF;
                if (in_last) phase[i] = 2;
                else if (next_addr[i] == top[i]) phase[i] = 3;
                next_addr[i] = (next_addr[i] == top[i]) ? 0 : next_addr[i] + 1;
            end else if (start && phase[i] != 1) begin
                phase[i] = 1; next_addr[i] = base[i]; count[i] = 0; csum[i] = 0;
            end
        end
    endtask

    task automatic check_inst(input int i);
        logic [31:0] a;
        logic [31:0] c;
        logic [31:0] ea;
        logic [35:0] ent;
        a  = (i == 2) ? {29'b0, addr2} : {12'b0, addr_o[i]};
        c  = (i == 2) ? {28'b0, cnt2} : {11'b0, cnt_o[i]};
        ea = ewe[i] ? ewaddr[i] : (phase[i] == 2) ? (int'(fetch_addr) & top[i]) : next_addr[i];
        check_val($sformatf("u%0d.mem_we", i), {31'b0, we_o[i]}, ewe[i]);
        check_val($sformatf("u%0d.in_ready", i), {31'b0, rdy_o[i]}, phase[i] == 1);
        check_val($sformatf("u%0d.cpu_hold", i), {31'b0, hold_o[i]}, phase[i] != 2);
        check_val($sformatf("u%0d.load_done", i), {31'b0, done_o[i]}, phase[i] == 2);
        check_val($sformatf("u%0d.load_err", i), {31'b0, err_o[i]}, phase[i] == 3);
        check_val($sformatf("u%0d.word_count", i), c, count[i]);
        check_val($sformatf("u%0d.mem_addr", i), a, ea);
        check_val($sformatf("u%0d.mem_wdata", i), {16'b0, wd_o[i]}, ewdata[i]);
`ifdef IMEM_LOAD_CHECKSUM_EN
        check_val($sformatf("u%0d.load_csum", i), {16'b0, cs_o[i]}, csum[i]);
`endif
        if (i == 0 && we_o[0]) begin
            check_val("sb_avail", {31'b0, exp_q.size() != 0}, 1);
            if (exp_q.size() != 0) begin
                ent = exp_q.pop_front();
                check_val("sb_write", {addr_o[0][15:0], wd_o[0]}, {ent[31:16], ent[15:0]});
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) check_inst(i);
    endtask

    task automatic step(input logic s, input logic v, input logic l, input logic [15:0] d,
                        input logic [19:0] fa);
        start = s; in_valid = v; in_last = l; in_data = d; fetch_addr = fa;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        check_all();
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("u%0d.rst_we", i), {31'b0, we_o[i]}, 0);
            check_val($sformatf("u%0d.rst_hold", i), {31'b0, hold_o[i]}, 1);
            check_val($sformatf("u%0d.rst_rdy", i), {31'b0, rdy_o[i]}, 0);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        check_all();
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_all();

        // directed program of three words, then fetch takes over the port
        step(1, 0, 0, 16'h0000, 20'd0);
        step(0, 1, 0, 16'h1234, 20'd0);
        step(0, 1, 0, 16'hABCD, 20'd0);
        step(0, 1, 1, 16'h0001, 20'd0);
        step(0, 0, 0, 16'h0000, 20'd5);
        check_val("directed_count", {11'b0, cnt_o[0]}, 3);
        check_val("directed_fetch", {12'b0, addr_o[0]}, 5);

        // gapped stream
        step(1, 0, 0, 16'h0000, 20'd5);
        step(0, 1, 0, 16'($urandom), 20'd5);
        step(0, 0, 0, 16'h0000, 20'd5);
        step(0, 0, 0, 16'h0000, 20'd5);
        step(0, 1, 1, 16'($urandom), 20'd5);
        step(0, 0, 0, 16'h0000, 20'd9);

        // nine unterminated words overflow the 3-bit instance
        step(1, 0, 0, 16'h0000, 20'd0);
        for (int k = 0; k < 9; k++) step(0, 1, 0, 16'($urandom), 20'd0);
        check_val("ovf_err", {31'b0, err_o[2]}, 1);
        check_val("ovf_count", {28'b0, cnt2}, 8);
        step(1, 0, 0, 16'h0000, 20'd0);
        check_val("ovf_clear", {31'b0, err_o[2]}, 0);
        step(0, 1, 1, 16'($urandom), 20'd0);
        step(0, 0, 0, 16'h0000, 20'd3);

        // restart from DONE, start with a concurrent handshake attempt
        step(1, 1, 0, 16'h5555, 20'd3);
        step(0, 1, 0, 16'hFFFF, 20'd3);
        step(0, 1, 1, 16'h0002, 20'd3);
`ifdef IMEM_LOAD_CHECKSUM_EN
        check_val("csum_fixed", {16'b0, cs_o[0]}, 32'h0001);
`endif
        step(0, 0, 0, 16'h0000, 20'd7);

        // reset after two of four words
        step(1, 0, 0, 16'h0000, 20'd0);
        step(0, 1, 0, 16'($urandom), 20'd0);
        step(0, 1, 0, 16'($urandom), 20'd0);
        async_reset();
        step(1, 0, 0, 16'h0000, 20'd0);
        step(0, 1, 1, 16'($urandom), 20'd0);

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 99) == 0) async_reset();
            step($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) == 0, 16'($urandom), 20'($urandom));
        end

        check_val("sb_drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
